// File: rtl/bilateral_frame_seq.sv
// Frame-level sequencer for the 5x5 bilateral filter stage.
// Clears the filter, streams exactly one frame of gray pixels into it,
// waits for the pipeline to drain, and counts qualified filter outputs.
// All ports are single-cycle valid/ready style:
//   a pixel moves from the source when src_valid && src_ready on a rising
//   clock edge; src_ready never depends on src_valid.
module bilateral_frame_seq #(
  parameter int IMAGE_WIDTH  = 320,
  parameter int IMAGE_HEIGHT = 240,
  parameter int CLR_CYCLES   = 4,
  parameter int DRAIN_CYCLES = 3,
  parameter int MAX_STALL    = 1024,
  parameter int EXPECTED_OUT = (IMAGE_WIDTH - 4) * (IMAGE_HEIGHT - 4)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  input  logic        src_valid,
  input  logic [7:0]  src_pix,
  output logic        src_ready,
  output logic        filt_rst,
  output logic        filt_gray_valid,
  output logic [7:0]  filt_gray,
  input  logic        filt_bilat_valid,
  output logic        out_strobe,
  output logic [31:0] out_count,
  output logic        err_timeout,
  output logic        err_count,
  output logic        err_overrun,
  output logic [2:0]  dbg_state
);

  localparam int CW  = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
  localparam int RW  = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam int SW  = $clog2(MAX_STALL);
  localparam int KW  = (CLR_CYCLES   > 1) ? $clog2(CLR_CYCLES)   : 1;
  localparam int DW  = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic [SW-1:0] stall_q;
  logic [KW-1:0] clr_q;
  logic [DW-1:0] drn_q;
  logic          rst_hold_q;
  logic          aborted_q;
  logic          gv_q;
  logic [7:0]    gray_q;
  logic [1:0]    vd_q;
  logic [31:0]   out_count_q, out_count_d;
  logic          err_timeout_q, err_count_q, err_overrun_q;

  logic start_ok, abort_act, accept, last_pix, stall_hit, count_win;

  assign start_ok  = (state_q == S_IDLE) && start && !abort;
  assign abort_act = abort && ((state_q == S_CLEAR) || (state_q == S_STREAM) ||
                               (state_q == S_DRAIN));
  assign accept    = src_valid && src_ready;
  assign last_pix  = accept && (col_q == CW'(IMAGE_WIDTH - 1)) &&
                     (row_q == RW'(IMAGE_HEIGHT - 1));
  assign stall_hit = (state_q == S_STREAM) && !src_valid &&
                     (stall_q == SW'(MAX_STALL - 1));
  assign count_win = (state_q == S_STREAM) || (state_q == S_DRAIN) ||
                     (state_q == S_DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; abort takes priority over every other exit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_ok) state_d = S_CLEAR;
      S_CLEAR:  if (abort) state_d = S_DONE;
                else if (clr_q == KW'(CLR_CYCLES - 1)) state_d = S_STREAM;
      S_STREAM: if (abort) state_d = S_DONE;
                else if (last_pix) state_d = S_DRAIN;
                else if (stall_hit) state_d = S_DONE;
      S_DRAIN:  if (abort) state_d = S_DONE;
                else if (drn_q == DW'(DRAIN_CYCLES - 1)) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state; filter reset also covers rst plus one cycle.
  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    src_ready = (state_q == S_STREAM) && !abort;
    filt_rst  = rst || rst_hold_q || (state_q == S_CLEAR) ||
                ((state_q == S_DONE) && aborted_q);
    dbg_state = state_q;
  end

  // Pixel forwarding, valid history for output qualification, phase counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      rst_hold_q <= 1'b1;
      aborted_q  <= 1'b0;
      gv_q       <= 1'b0;
      gray_q     <= 8'd0;
      vd_q       <= 2'b00;
      clr_q      <= '0;
      drn_q      <= '0;
      col_q      <= '0;
      row_q      <= '0;
      stall_q    <= '0;
    end else begin
      rst_hold_q <= 1'b0;
      aborted_q  <= abort_act;
      gv_q       <= accept;
      if (accept) gray_q <= src_pix;
      vd_q       <= {vd_q[0], gv_q};
      clr_q      <= (state_q == S_CLEAR) ? clr_q + KW'(1) : '0;
      drn_q      <= (state_q == S_DRAIN) ? drn_q + DW'(1) : '0;
      if (start_ok) begin
        col_q <= '0;
        row_q <= '0;
      end else if (accept) begin
        if (col_q == CW'(IMAGE_WIDTH - 1)) begin
          col_q <= '0;
          row_q <= row_q + RW'(1);
        end else begin
          col_q <= col_q + CW'(1);
        end
      end
      if (start_ok)                  stall_q <= '0;
      else if (state_q == S_STREAM)  stall_q <= src_valid ? '0 : stall_q + SW'(1);
    end
  end

  // Saturating count of qualified outputs, cleared by an accepted start.
  always_comb begin
    out_count_d = out_count_q;
    if (start_ok)
      out_count_d = '0;
    else if (out_strobe && count_win && (out_count_q != '1))
      out_count_d = out_count_q + 32'd1;
  end

  // Count register and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_count_q   <= '0;
      err_timeout_q <= 1'b0;
      err_count_q   <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      out_count_q <= out_count_d;
      if (start_ok) begin
        err_timeout_q <= 1'b0;
        err_count_q   <= 1'b0;
        err_overrun_q <= 1'b0;
      end else begin
        if (start && busy)           err_overrun_q <= 1'b1;
        if (stall_hit && !abort)     err_timeout_q <= 1'b1;
        if ((state_q == S_DONE) && !aborted_q)
          err_count_q <= (out_count_d != 32'(EXPECTED_OUT));
      end
    end
  end

  assign out_strobe      = filt_bilat_valid && vd_q[1];
  assign filt_gray_valid = gv_q;
  assign filt_gray       = gray_q;
  assign out_count       = out_count_q;
  assign err_timeout     = err_timeout_q;
  assign err_count       = err_count_q;
  assign err_overrun     = err_overrun_q;

endmodule
